// File: rtl/audio_stream_arbiter.sv
// Selects or saturating-mixes two stereo sample streams into a registered
// valid/ready output; mode changes wait for the output register to drain.
module audio_stream_arbiter #(
   parameter int BW    = 24,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              arst,
   input  logic [1:0]        cfg_mode,
   input  logic              cfg_valid,
   input  logic [2*BW-1:0]   s0_data,
   input  logic              s0_valid,
   output logic              s0_ready,
   input  logic [2*BW-1:0]   s1_data,
   input  logic              s1_valid,
   output logic              s1_ready,
   output logic [2*BW-1:0]   m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [1:0]        active_mode,
   output logic              busy,
   output logic [CNT_W-1:0]  sample_cnt
);

   localparam logic [1:0] MODE_OFF  = 2'd0;
   localparam logic [1:0] MODE_SRC0 = 2'd1;
   localparam logic [1:0] MODE_SRC1 = 2'd2;
   localparam logic [1:0] MODE_MIX  = 2'd3;

   localparam logic [BW-1:0] SAT_MAX = {1'b0, {(BW-1){1'b1}}};
   localparam logic [BW-1:0] SAT_MIN = {1'b1, {(BW-1){1'b0}}};

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [1:0]        pending_reg;
   logic [1:0]        active_mode_reg, active_mode_next;
   logic              m_valid_reg;
   logic [2*BW-1:0]   m_data_reg;
   logic [CNT_W-1:0]  sample_cnt_reg;

   logic              out_free;
   logic              accept;
   logic              in_xfer;
   logic              s0_ready_c, s1_ready_c;
   logic [2*BW-1:0]   sel_data;
   logic [2*BW-1:0]   mix_data;

   // Per-channel saturating add: one extra bit catches overflow in either direction.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_mix
         logic [BW:0] sum;
         assign sum = {s0_data[gi*BW+BW-1], s0_data[gi*BW +: BW]}
                    + {s1_data[gi*BW+BW-1], s1_data[gi*BW +: BW]};
         assign mix_data[gi*BW +: BW] = (sum[BW] != sum[BW-1])
                                      ? (sum[BW] ? SAT_MIN : SAT_MAX)
                                      : sum[BW-1:0];
      end
   endgenerate

   assign out_free = !m_valid_reg || m_ready;
   assign accept   = (state_reg == ST_RUN) && out_free;

   always_comb begin
      s0_ready_c = 1'b0;
      s1_ready_c = 1'b0;
      in_xfer    = 1'b0;
      sel_data   = s0_data;
      case (active_mode_reg)
         MODE_SRC0: begin
            s0_ready_c = accept;
            in_xfer    = accept && s0_valid;
            sel_data   = s0_data;
         end
         MODE_SRC1: begin
            s1_ready_c = accept;
            in_xfer    = accept && s1_valid;
            sel_data   = s1_data;
         end
         MODE_MIX: begin
            // Both sources move together or not at all.
            s0_ready_c = accept && s0_valid && s1_valid;
            s1_ready_c = s0_ready_c;
            in_xfer    = s0_ready_c;
            sel_data   = mix_data;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      state_next       = state_reg;
      active_mode_next = active_mode_reg;
      case (state_reg)
         ST_RUN: begin
            if (pending_reg != active_mode_reg)
               state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pending_reg == active_mode_reg) begin
               state_next = ST_RUN;
            end else if (out_free) begin
               state_next       = ST_RUN;
               active_mode_next = pending_reg;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_reg       <= ST_RUN;
         pending_reg     <= MODE_OFF;
         active_mode_reg <= MODE_OFF;
      end else begin
         state_reg       <= state_next;
         active_mode_reg <= active_mode_next;
         if (cfg_valid)
            pending_reg <= cfg_mode;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         m_valid_reg    <= 1'b0;
         m_data_reg     <= '0;
         sample_cnt_reg <= '0;
      end else begin
         if (in_xfer) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= sel_data;
         end else if (m_ready) begin
            m_valid_reg <= 1'b0;
         end
         if (m_valid_reg && m_ready)
            sample_cnt_reg <= sample_cnt_reg + 1'b1;
      end
   end

   assign s0_ready    = s0_ready_c;
   assign s1_ready    = s1_ready_c;
   assign m_data      = m_data_reg;
   assign m_valid     = m_valid_reg;
   assign active_mode = active_mode_reg;
   assign busy        = (state_reg == ST_DRAIN);
   assign sample_cnt  = sample_cnt_reg;

endmodule

// File: tb/tb_audio_stream_arbiter.sv
// Directed scenario bench for audio_stream_arbiter with hand-computed expectations.
module tb_audio_stream_arbiter;

   localparam int BW    = 24;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              arst = 1'b0;
   logic [1:0]        cfg_mode = 2'd0;
   logic              cfg_valid = 1'b0;
   logic [2*BW-1:0]   s0_data = '0;
   logic              s0_valid = 1'b0;
   logic              s0_ready;
   logic [2*BW-1:0]   s1_data = '0;
   logic              s1_valid = 1'b0;
   logic              s1_ready;
   logic [2*BW-1:0]   m_data;
   logic              m_valid;
   logic              m_ready = 1'b1;
   logic [1:0]        active_mode;
   logic              busy;
   logic [CNT_W-1:0]  sample_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int s0_hs    = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

   audio_stream_arbiter #(.BW(BW), .CNT_W(CNT_W)) dut (
      .clk(clk), .arst(arst),
      .cfg_mode(cfg_mode), .cfg_valid(cfg_valid),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .active_mode(active_mode), .busy(busy), .sample_cnt(sample_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!arst && s0_valid && s0_ready) s0_hs++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input logic [1:0] m);
      cfg_mode = m; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL set_mode_busy: got %b expected 1", busy); end
      tick();
      n_checks++;
      if (busy !== 1'b0 || active_mode !== m) begin
         n_fail++; $display("FAIL set_mode_done: busy=%b mode=%0d expected busy=0 mode=%0d", busy, active_mode, m);
      end
   endtask

   task automatic test_reset();
      arst = 1'b1;
      s0_valid = 1'b1; s1_valid = 1'b1;
      #12;
      @(posedge clk); #1;
      arst = 1'b0;
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== '0) begin n_fail++; $display("FAIL reset_out: m_valid=%b m_data=%h expected 0/0", m_valid, m_data); end
      n_checks++;
      if (sample_cnt !== '0 || active_mode !== 2'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: cnt=%h mode=%0d busy=%b expected 0/0/0", sample_cnt, active_mode, busy);
      end
      n_checks++;
      if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: s0=%b s1=%b expected 0/0", s0_ready, s1_ready); end
      repeat (3) tick();
      n_checks++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL off_no_output: m_valid=%b expected 0", m_valid); end
      s0_valid = 1'b0; s1_valid = 1'b0;
   endtask

   task automatic test_src0();
      set_mode(2'd1);
      s0_valid = 1'b1; s0_data = 48'h000001_000002; s1_valid = 1'b1;
      #1;
      n_checks++;
      if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL src0_ready: s0=%b s1=%b expected 1/0", s0_ready, s1_ready); end
      tick();
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 48'h000001_000002) begin n_fail++; $display("FAIL src0_first: v=%b d=%h expected 1/000001000002", m_valid, m_data); end
      s0_data = 48'h000003_000004;
      tick();
      n_checks++;
      if (m_data !== 48'h000003_000004 || sample_cnt !== 16'd1) begin n_fail++; $display("FAIL src0_second: d=%h cnt=%0d expected 000003000004/1", m_data, sample_cnt); end
      s0_valid = 1'b0; s1_valid = 1'b0;
      tick();
      exp_cnt = 16'd2;
      n_checks++;
      if (m_valid !== 1'b0 || sample_cnt !== exp_cnt) begin n_fail++; $display("FAIL src0_end: v=%b cnt=%0d expected 0/%0d", m_valid, sample_cnt, exp_cnt); end
   endtask

   task automatic test_mix();
      set_mode(2'd3);
      s0_data = 48'h7FFFF0_800010; s1_data = 48'h000020_FFFFE0;
      s0_valid = 1'b1; s1_valid = 1'b1;
      #1;
      n_checks++;
      if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin n_fail++; $display("FAIL mix_ready: s0=%b s1=%b expected 1/1", s0_ready, s1_ready); end
      tick();
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 48'h7FFFFF_800000) begin n_fail++; $display("FAIL mix_sat: d=%h expected 7fffff800000", m_data); end
      s0_data = 48'h000005_FFFFFB; s1_data = 48'h000003_000002;
      tick();
      n_checks++;
      if (m_data !== 48'h000008_FFFFFD) begin n_fail++; $display("FAIL mix_add: d=%h expected 000008fffffd", m_data); end
      s0_valid = 1'b0; s1_valid = 1'b0;
      tick();
      exp_cnt = exp_cnt + 16'd2;
      n_checks++;
      if (m_valid !== 1'b0 || sample_cnt !== exp_cnt) begin n_fail++; $display("FAIL mix_cnt: v=%b cnt=%0d expected 0/%0d", m_valid, sample_cnt, exp_cnt); end
   endtask

   task automatic test_mix_wait();
      s0_valid = 1'b1; s0_data = 48'h000001_000001; s1_valid = 1'b0; s1_data = 48'h000002_FFFFFF;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++; $display("FAIL mix_wait_ready: cyc=%0d s0=%b s1=%b expected 0/0", i, s0_ready, s1_ready); end
         tick();
         n_checks++;
         if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mix_wait_out: cyc=%0d m_valid=%b expected 0", i, m_valid); end
      end
      s1_valid = 1'b1;
      #1;
      n_checks++;
      if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin n_fail++; $display("FAIL mix_pair_ready: s0=%b s1=%b expected 1/1", s0_ready, s1_ready); end
      tick();
      s0_valid = 1'b0; s1_valid = 1'b0;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 48'h000003_000000) begin n_fail++; $display("FAIL mix_pair_out: v=%b d=%h expected 1/000003000000", m_valid, m_data); end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      n_checks++;
      if (m_valid !== 1'b0 || sample_cnt !== exp_cnt) begin n_fail++; $display("FAIL mix_pair_once: v=%b cnt=%0d expected 0/%0d", m_valid, sample_cnt, exp_cnt); end
   endtask

   task automatic test_drain_switch();
      int hs_start;
      set_mode(2'd1);
      hs_start = s0_hs;
      s0_valid = 1'b1; s0_data = 48'h111111_222222;
      tick();
      m_ready = 1'b0; s0_data = 48'h333333_444444;
      cfg_mode = 2'd2; cfg_valid = 1'b1;
      #1;
      n_checks++;
      if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_accept: s0_ready=%b expected 0", s0_ready); end
      tick();
      cfg_valid = 1'b0;
      tick();
      #1;
      n_checks++;
      if (busy !== 1'b1 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
         n_fail++; $display("FAIL drain_enter: busy=%b s0=%b s1=%b expected 1/0/0", busy, s0_ready, s1_ready);
      end
      tick();
      n_checks++;
      if (busy !== 1'b1 || m_data !== 48'h111111_222222 || m_valid !== 1'b1) begin
         n_fail++; $display("FAIL drain_stuck: busy=%b v=%b d=%h expected 1/1/111111222222", busy, m_valid, m_data);
      end
      m_ready = 1'b1;
      tick();
      exp_cnt = exp_cnt + 16'd1;
      n_checks++;
      if (active_mode !== 2'd2 || busy !== 1'b0 || m_valid !== 1'b0) begin
         n_fail++; $display("FAIL drain_exit: mode=%0d busy=%b v=%b expected 2/0/0", active_mode, busy, m_valid);
      end
      #1;
      n_checks++;
      if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin n_fail++; $display("FAIL src1_ready: s0=%b s1=%b expected 0/1", s0_ready, s1_ready); end
      n_checks++;
      if (s0_hs - hs_start !== 1 || sample_cnt !== exp_cnt) begin
         n_fail++; $display("FAIL src0_no_loss: handshakes=%0d cnt=%0d expected 1/%0d", s0_hs - hs_start, sample_cnt, exp_cnt);
      end
      s0_valid = 1'b0;
   endtask

   task automatic test_drain_cancel();
      s1_valid = 1'b1; s1_data = 48'h555555_666666;
      tick();
      s1_valid = 1'b0; m_ready = 1'b0;
      cfg_mode = 2'd1; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL cancel_drain: busy=%b expected 1", busy); end
      cfg_mode = 2'd2; cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || active_mode !== 2'd2 || m_valid !== 1'b1 || m_data !== 48'h555555_666666) begin
         n_fail++; $display("FAIL cancel_back: busy=%b mode=%0d v=%b d=%h expected 0/2/1/555555666666", busy, active_mode, m_valid, m_data);
      end
      m_ready = 1'b1;
      tick();
      s1_valid = 1'b1; s1_data = 48'h777777_888888;
      tick();
      s1_valid = 1'b0;
      tick();
      exp_cnt = exp_cnt + 16'd2;
      n_checks++;
      if (sample_cnt !== exp_cnt || m_data !== 48'h777777_888888) begin
         n_fail++; $display("FAIL cancel_cnt: cnt=%0d d=%h expected %0d/777777888888", sample_cnt, m_data, exp_cnt);
      end
   endtask

   task automatic test_async_reset();
      set_mode(2'd3);
      s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 48'h000010_000010; s1_data = 48'h000001_000001;
      tick();
      s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 48'h000011_000011) begin n_fail++; $display("FAIL pre_reset: v=%b d=%h expected 1/000011000011", m_valid, m_data); end
      #2;
      arst = 1'b1;
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || sample_cnt !== '0 || active_mode !== 2'd0 || m_data !== '0) begin
         n_fail++; $display("FAIL async_reset: v=%b cnt=%0d mode=%0d d=%h expected 0/0/0/0", m_valid, sample_cnt, active_mode, m_data);
      end
      @(posedge clk); #1;
      arst = 1'b0; m_ready = 1'b1;
      exp_cnt = '0;
   endtask

   task automatic test_cnt_wrap();
      int n;
      set_mode(2'd2);
      n = 65535 - int'(exp_cnt);
      s1_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         s1_data = 48'(i);
         tick();
      end
      s1_valid = 1'b0;
      tick();
      n_checks++;
      if (sample_cnt !== 16'hFFFF || m_valid !== 1'b0) begin n_fail++; $display("FAIL cnt_max: cnt=%h v=%b expected ffff/0", sample_cnt, m_valid); end
      s1_valid = 1'b1;
      tick();
      s1_valid = 1'b0;
      tick();
      n_checks++;
      if (sample_cnt !== 16'h0000) begin n_fail++; $display("FAIL cnt_wrap: cnt=%h expected 0000", sample_cnt); end
   endtask

   initial begin
      test_reset();
      test_src0();
      test_mix();
      test_mix_wait();
      test_drain_switch();
      test_drain_cancel();
      test_async_reset();
      test_cnt_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
